// File: rtl/bcd_display_counter_if.sv
// bcd_display_counter_if
//   Bundle of the control and display signals of bcd_display_counter.
//   The clock (C) and the reset (CLR) stay plain ports on the counter.
//   master : drives CE/UP/LOAD/LOAD_VAL/BLANK and observes the outputs.
//   slave  : the counter itself.
//   CE        count enable (gates the prescaler)
//   UP        direction, 1 = increment
//   LOAD      synchronous parallel load of LOAD_VAL
//   LOAD_VAL  BCD load value, digit i at [4i+3:4i]
//   BLANK     leading-zero blanking enable
//   BCD_OUT   current count, digit 0 least significant
//   segments  7-segment patterns, digit i at [8i+7:8i], Dgfedcba, active-high
//   WRAP      one-cycle pulse on wrap/borrow
`timescale 1ns/1ps
interface bcd_display_counter_if #(
  parameter int DIGITS = 2
);
  logic                  CE;
  logic                  UP;
  logic                  LOAD;
  logic [4*DIGITS-1:0]   LOAD_VAL;
  logic                  BLANK;
  logic [4*DIGITS-1:0]   BCD_OUT;
  logic [8*DIGITS-1:0]   segments;
  logic                  WRAP;

  modport master (
    output CE, UP, LOAD, LOAD_VAL, BLANK,
    input  BCD_OUT, segments, WRAP
  );

  modport slave (
    input  CE, UP, LOAD, LOAD_VAL, BLANK,
    output BCD_OUT, segments, WRAP
  );
endinterface

// File: rtl/bcd_display_counter.sv
// bcd_display_counter
//   N-digit BCD up/down counter with a power-of-two prescaler, parallel
//   load, wrap pulse and a registered 7-segment decoder with optional
//   leading-zero blanking.
//   C    : clock, rising edge
//   CLR  : asynchronous active-high reset
//   bus  : bcd_display_counter_if.slave (CE, UP, LOAD, LOAD_VAL, BLANK in;
//          BCD_OUT, segments, WRAP out)
`timescale 1ns/1ps
module bcd_display_counter #(
  parameter int DIGITS        = 2,
  parameter int PRESCALE_BITS = 15
) (
  input logic                  C,
  input logic                  CLR,
  bcd_display_counter_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int SW = 8 * DIGITS;
  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);
  localparam logic [7:0] SEG_ZERO = 8'b0011_1111;

  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  logic [W-1:0]             bcd_q, bcd_d;
  logic [SW-1:0]            seg_q, seg_d;
  logic                     wrap_q, wrap_d;
  logic [W:0]               stepped;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'b0011_1111;
      4'd1:    p = 8'b0000_0110;
      4'd2:    p = 8'b0101_1011;
      4'd3:    p = 8'b0100_1111;
      4'd4:    p = 8'b0110_0110;
      4'd5:    p = 8'b0110_1101;
      4'd6:    p = 8'b0111_1101;
      4'd7:    p = 8'b0000_0111;
      4'd8:    p = 8'b0111_1111;
      4'd9:    p = 8'b0110_1111;
      default: p = 8'b0000_0000;
    endcase
    return p;
  endfunction

  // Returns {wrap, next value}; the carry/borrow ripples from digit 0 up and
  // is still set past the top digit only when every digit wrapped.
  function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   dig;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (dig == 4'd9) dig = 4'd0;
          else begin
            dig = dig + 4'd1;
            c   = 1'b0;
          end
        end else begin
          if (dig == 4'd0) dig = 4'd9;
          else begin
            dig = dig - 4'd1;
            c   = 1'b0;
          end
        end
      end
      r[4*i +: 4] = dig;
    end
    return {c, r};
  endfunction

  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  // Walk from the top digit down; 'lead' stays set while every digit seen
  // so far (including the current one) is zero.
  function automatic logic [SW-1:0] decode(input logic [W-1:0] v, input logic blank);
    logic [SW-1:0] r;
    logic          lead;
    r    = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] != 4'd0) lead = 1'b0;
      r[8*i +: 8] = (blank && lead && (i != 0)) ? 8'h00 : seg7(v[4*i +: 4]);
    end
    return r;
  endfunction

  assign stepped = bcd_step(bcd_q, bus.UP);
  assign seg_d   = decode(bcd_q, bus.BLANK);

  always_comb begin
    pre_d  = pre_q;
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (bus.LOAD) begin
      bcd_d = sanitize(bus.LOAD_VAL);
      pre_d = '0;
    end else if (bus.CE) begin
      pre_d = pre_q + PRE_ONE;
      if (&pre_q) begin
        bcd_d  = stepped[W-1:0];
        wrap_d = stepped[W];
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      pre_q  <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
      seg_q  <= {DIGITS{SEG_ZERO}};
    end else begin
      pre_q  <= pre_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.BCD_OUT  = bcd_q;
  assign bus.segments = seg_q;
  assign bus.WRAP     = wrap_q;
endmodule

// File: tb/tb_bcd_display_counter.sv
`timescale 1ns/1ps
module tb_bcd_display_counter;
  localparam int DIGITS = 2;
  localparam int PB     = 2;
  localparam int PN     = 1 << PB;
  localparam int MOD    = 100;
  localparam logic [7:0] LUT [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic C;
  logic CLR;
  int   checks;
  int   errors;

  // reference model state: plain integers
  int          m_val;
  int          m_pre;
  logic        m_wrap;
  logic [31:0] m_seg;

  bcd_display_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_display_counter #(.DIGITS(DIGITS), .PRESCALE_BITS(PB)) dut (
    .C   (C),
    .CLR (CLR),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (32'((v / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] seg_model(input int v, input logic blank);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!(blank && i > 0 && v < p)) r = r | (32'(LUT[(v / p) % 10]) << (8 * i));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int load_model(input logic [4*DIGITS-1:0] lv);
    int r, p, nib;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'((lv >> (4 * i)) & 15);
      if (nib <= 9) r = r + nib * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " bcd"},  32'(bus.BCD_OUT),  to_bcd(m_val));
    check({tag, " wrap"}, 32'(bus.WRAP),     32'(m_wrap));
    check({tag, " seg"},  32'(bus.segments), m_seg);
  endtask

  task automatic model_reset();
    m_val  = 0;
    m_pre  = 0;
    m_wrap = 1'b0;
    m_seg  = {DIGITS{8'h3F}};
  endtask

  // advance the model by one edge using the current inputs, then wait for
  // the edge and settle 1ns past it
  task automatic tick();
    logic [31:0] seg_next;
    seg_next = seg_model(m_val, bus.BLANK);
    m_wrap = 1'b0;
    if (bus.LOAD) begin
      m_val = load_model(bus.LOAD_VAL);
      m_pre = 0;
    end else if (bus.CE) begin
      if (m_pre == PN - 1) begin
        if (bus.UP) begin
          m_wrap = (m_val == MOD - 1);
          m_val  = (m_val + 1) % MOD;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + MOD - 1) % MOD;
        end
      end
      m_pre = (m_pre + 1) % PN;
    end
    m_seg = seg_next;
    @(posedge C);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.LOAD     = 1'b1;
    bus.LOAD_VAL = v;
    tick();
    check_all("load");
    bus.LOAD = 1'b0;
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    #1;
    model_reset();
    check("clr bcd",  32'(bus.BCD_OUT),  32'h0);
    check("clr wrap", 32'(bus.WRAP),     32'h0);
    check("clr seg",  32'(bus.segments), 32'h3F3F);
    CLR = 1'b0;
  endtask

  initial begin
    int wraps;
    checks       = 0;
    errors       = 0;
    CLR          = 1'b1;
    bus.CE       = 1'b1;
    bus.UP       = 1'b1;
    bus.LOAD     = 1'b1;
    bus.LOAD_VAL = 8'h55;
    bus.BLANK    = 1'b1;
    model_reset();
    #12;
    check("reset bcd",  32'(bus.BCD_OUT),  32'h0);
    check("reset wrap", 32'(bus.WRAP),     32'h0);
    check("reset seg",  32'(bus.segments), 32'h3F3F);
    bus.LOAD  = 1'b0;
    bus.CE    = 1'b0;
    bus.BLANK = 1'b0;
    CLR       = 1'b0;

    // 1: free-running count up
    bus.CE = 1'b1;
    bus.UP = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check_all("up");
      if (i == 4) check("t1 first step", 32'(bus.BCD_OUT), 32'h01);
    end
    check("t1 bcd at 40", 32'(bus.BCD_OUT), 32'h10);
    bus.CE = 1'b0;
    tick();
    check("t1 seg 10", 32'(bus.segments), 32'h063F);

    // 2: wrap up from 98
    do_load(8'h98);
    bus.CE = 1'b1;
    wraps  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("wrapup");
      if (bus.WRAP === 1'b1) wraps++;
    end
    check("t2 bcd", 32'(bus.BCD_OUT), 32'h00);
    check("t2 wrap", 32'(bus.WRAP), 32'h1);
    bus.CE = 1'b0;
    tick();
    check("t2 wrap drop", 32'(bus.WRAP), 32'h0);
    check("t2 wrap count", 32'(wraps), 32'd1);

    // 3: borrow down from 01
    do_load(8'h01);
    bus.UP = 1'b0;
    bus.CE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("wrapdn");
    end
    check("t3 bcd", 32'(bus.BCD_OUT), 32'h99);
    check("t3 wrap", 32'(bus.WRAP), 32'h1);
    bus.CE = 1'b0;
    tick();
    check("t3 seg 99", 32'(bus.segments), 32'h6F6F);

    // 4: LOAD coincident with prescaler rollover, invalid digit
    bus.UP = 1'b1;
    do_load(8'h30);
    bus.CE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("pre");
    end
    bus.LOAD     = 1'b1;
    bus.LOAD_VAL = 8'h4C;
    tick();
    check_all("t4 load");
    check("t4 bcd", 32'(bus.BCD_OUT), 32'h40);
    check("t4 wrap", 32'(bus.WRAP), 32'h0);
    bus.LOAD = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_all("t4 run");
      check("t4 step timing", 32'(bus.BCD_OUT), (i == 4) ? 32'h41 : 32'h40);
    end

    // 5: blanking
    bus.CE    = 1'b0;
    bus.BLANK = 1'b1;
    do_load(8'h05);
    tick();
    check("t5 blank 05", 32'(bus.segments), 32'h006D);
    do_load(8'h00);
    tick();
    check("t5 blank 00", 32'(bus.segments), 32'h003F);
    bus.BLANK = 1'b0;
    do_load(8'h05);
    tick();
    check("t5 noblank 05", 32'(bus.segments), 32'h3F6D);

    // 6: CE toggled every clock, then CLR mid-count
    do_load(8'h00);
    for (int i = 0; i < 38; i++) begin
      bus.CE = (i % 2 == 0);
      tick();
      check_all("toggle");
      if (i == 31) check("t6 steps", 32'(bus.BCD_OUT), 32'h04);
    end
    clr_pulse();
    bus.CE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("after clr");
    end

    // randomized operation against the model
    for (int i = 0; i < 400; i++) begin
      bus.CE       = ($urandom_range(0, 3) != 0);
      bus.UP       = $urandom_range(0, 1) == 1;
      bus.LOAD     = ($urandom_range(0, 15) == 0);
      bus.LOAD_VAL = 8'($urandom);
      bus.BLANK    = ($urandom_range(0, 7) == 0) ? ~bus.BLANK : bus.BLANK;
      if ($urandom_range(0, 79) == 0) clr_pulse();
      tick();
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
